// File: rtl/key_pkg.sv
// Shared types, default timing and width helper for the DE-board push-button conditioner.
package key_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam int DEFAULT_NUM_KEYS        = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500_000;
    localparam int DEFAULT_HOLD_CYCLES     = 25_000_000;
    localparam int DEFAULT_REPEAT_CYCLES   = 5_000_000;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_channel.sv
// One button channel: two-flop synchroniser, debounce FSM and auto-repeat timer.
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    localparam int DB_W     = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = cnt_width(HOLD_MAX);

    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam bit                DB_SINGLE = (DEBOUNCE_CYCLES == 1);
    localparam bit                REPEAT_EN = (HOLD_CYCLES > 0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    logic              sync_meta;
    logic              sync_s;
    key_state_t        state, state_next;
    logic [DB_W-1:0]   cnt, cnt_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;
    logic              rep_phase, rep_phase_next;
    logic              press_next, release_next, repeat_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b1;
            sync_s    <= 1'b1;
        end else begin
            sync_meta <= key_raw_n;
            sync_s    <= sync_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RELEASED;
            cnt         <= '0;
            hold_cnt    <= '0;
            rep_phase   <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            hold_cnt    <= hold_next;
            rep_phase   <= rep_phase_next;
            key_press   <= press_next;
            key_release <= release_next;
            key_repeat  <= repeat_next;
            if (press_next)
                key_level <= 1'b1;
            else if (release_next)
                key_level <= 1'b0;
        end
    end

    // Debounce: a run of stable samples must complete before the level flips.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state)
            RELEASED: begin
                if (!sync_s) begin
                    if (DB_SINGLE) begin
                        state_next = PRESSED;
                        press_next = 1'b1;
                        cnt_next   = '0;
                    end else begin
                        state_next = PRESS_WAIT;
                        cnt_next   = DB_ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (sync_s) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next = PRESSED;
                    press_next = 1'b1;
                    cnt_next   = '0;
                end else if (cnt != '1) begin
                    cnt_next = cnt + DB_ONE;
                end
            end
            PRESSED: begin
                if (sync_s) begin
                    if (DB_SINGLE) begin
                        state_next   = RELEASED;
                        release_next = 1'b1;
                        cnt_next     = '0;
                    end else begin
                        state_next = RELEASE_WAIT;
                        cnt_next   = DB_ONE;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (!sync_s) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == DB_LAST) begin
                    state_next   = RELEASED;
                    release_next = 1'b1;
                    cnt_next     = '0;
                end else if (cnt != '1) begin
                    cnt_next = cnt + DB_ONE;
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

    // Auto-repeat only advances in PRESSED, so it freezes while a release is being qualified.
    always_comb begin
        hold_next      = hold_cnt;
        rep_phase_next = rep_phase;
        repeat_next    = 1'b0;
        if (press_next) begin
            hold_next      = '0;
            rep_phase_next = 1'b0;
        end else if (REPEAT_EN && state == PRESSED && !release_next) begin
            if (hold_cnt == (rep_phase ? REP_LAST : HOLD_LAST)) begin
                repeat_next    = 1'b1;
                hold_next      = '0;
                rep_phase_next = 1'b1;
            end else if (hold_cnt != '1) begin
                hold_next = hold_cnt + HOLD_ONE;
            end
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// Conditions the active-low KEY[3:0] pins into debounced levels and press/release/repeat pulses.
module key_conditioner
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = DEFAULT_NUM_KEYS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat
);

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_channel (
            .clk        (CLOCK_50),
            .rst_n      (reset_n),
            .key_raw_n  (key_n[gi]),
            .key_level  (key_level[gi]),
            .key_press  (key_press[gi]),
            .key_release(key_release[gi]),
            .key_repeat (key_repeat[gi])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/hold/repeat timing.
module tb_key_conditioner;

    logic       CLOCK_50;
    logic       reset_n;
    logic [3:0] key_n;
    logic [3:0] key_level, key_press, key_release, key_repeat;

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc     = 0;
    int press_cnt[4];
    int release_cnt[4];
    int repeat_cnt[4];
    int last_press_cyc[4];
    int last_release_cyc[4];
    int overlap_cnt = 0;
    int rep_q[$];

    key_conditioner #(
        .NUM_KEYS       (4),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (10),
        .REPEAT_CYCLES  (3)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_repeat (key_repeat)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    // Pulse log, sampled on the falling edge where every registered output is stable.
    always @(negedge CLOCK_50) begin
        ncyc = ncyc + 1;
        for (int i = 0; i < 4; i++) begin
            if (key_press[i]) begin
                press_cnt[i]++;
                last_press_cyc[i] = ncyc;
            end
            if (key_release[i]) begin
                release_cnt[i]++;
                last_release_cyc[i] = ncyc;
            end
            if (key_repeat[i]) begin
                repeat_cnt[i]++;
                if (i == 3) rep_q.push_back(ncyc);
            end
        end
        if (((key_press | key_release) & key_repeat) != 4'b0) overlap_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLOCK_50);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] kn, input int cycles);
        key_n = kn;
        tick(cycles);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    initial begin
        int t0, t1, tp, pc;

        // Reset with key 2 held down
        reset_n = 1'b0;
        key_n   = 4'b1011;
        tick(3);
        checkOutput("reset_outputs", {key_level, key_press, key_release, key_repeat}, 0);
        tick(2);
        checkOutput("reset_outputs_late", {key_level, key_press, key_release, key_repeat}, 0);
        reset_n = 1'b1;
        t0 = ncyc;
        tick(8);
        checkOutput("held_at_reset_press_cnt", press_cnt[2], 1);
        checkOutput("held_at_reset_press_time", last_press_cyc[2], t0 + 6);
        checkOutput("held_at_reset_level", key_level, 4'b0100);

        t0 = ncyc;
        applyStimulus(4'b1111, 8);
        checkOutput("key2_release_cnt", release_cnt[2], 1);
        checkOutput("key2_release_time", last_release_cyc[2], t0 + 6);
        checkOutput("key2_release_level", key_level, 4'b0000);

        // Bounce on key 0 before a stable press
        applyStimulus(4'b1110, 3);
        applyStimulus(4'b1111, 1);
        t1 = ncyc;
        applyStimulus(4'b1110, 8);
        checkOutput("bounce_press_cnt", press_cnt[0], 1);
        checkOutput("bounce_press_time", last_press_cyc[0], t1 + 6);
        checkOutput("bounce_no_release", release_cnt[0], 0);
        checkOutput("bounce_level", key_level, 4'b0001);
        applyStimulus(4'b1111, 8);
        checkOutput("key0_release_cnt", release_cnt[0], 1);

        // Short release glitch on key 1, then a real release
        applyStimulus(4'b1101, 8);
        checkOutput("key1_press_cnt", press_cnt[1], 1);
        applyStimulus(4'b1111, 2);
        applyStimulus(4'b1101, 6);
        checkOutput("glitch_no_release", release_cnt[1], 0);
        checkOutput("glitch_no_repress", press_cnt[1], 1);
        checkOutput("glitch_level", key_level, 4'b0010);
        t0 = ncyc;
        applyStimulus(4'b1111, 8);
        checkOutput("key1_release_cnt", release_cnt[1], 1);
        checkOutput("key1_release_time", last_release_cyc[1], t0 + 6);
        checkOutput("key1_release_level", key_level, 4'b0000);

        // Auto-repeat on key 3
        rep_q.delete();
        t0 = ncyc;
        applyStimulus(4'b0111, 6);
        tp = t0 + 6;
        checkOutput("key3_press_time", last_press_cyc[3], tp);
        applyStimulus(4'b0111, 30);
        applyStimulus(4'b1111, 12);
        checkOutput("repeat_count", rep_q.size(), 8);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("repeat_time_%0d", i),
                        (i < rep_q.size()) ? rep_q[i] : -1, tp + 10 + 3 * i);
        checkOutput("key3_release_time", last_release_cyc[3], tp + 36);
        tick(20);
        checkOutput("no_repeat_after_release", repeat_cnt[3], 8);

        // Simultaneous presses and releases on keys 0 and 3
        applyStimulus(4'b0110, 5);
        checkOutput("simul_press_early", key_press, 4'b0000);
        tick(1);
        checkOutput("simul_press", key_press, 4'b1001);
        checkOutput("simul_level", key_level, 4'b1001);
        applyStimulus(4'b1111, 5);
        tick(1);
        checkOutput("simul_release", key_release, 4'b1001);
        tick(4);

        // Reset during PRESS_WAIT, key held through reset release
        pc = press_cnt[1];
        applyStimulus(4'b1101, 3);
        reset_n = 1'b0;
        tick(3);
        checkOutput("midreset_outputs", {key_level, key_press, key_release, key_repeat}, 0);
        checkOutput("midreset_no_press", press_cnt[1], pc);
        reset_n = 1'b1;
        t1 = ncyc;
        tick(8);
        checkOutput("midreset_press_cnt", press_cnt[1], pc + 1);
        checkOutput("midreset_press_time", last_press_cyc[1], t1 + 6);
        checkOutput("midreset_level", key_level, 4'b0010);

        checkOutput("no_pulse_overlap", overlap_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
